// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO.
// Bus responder: TXDATA push, STATUS read, BAUD divider read/write.
module mmio_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4,
  parameter int DIV_W        = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [3:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        uart_tx,
  output logic        tx_busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e state_q, state_d;

  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_q, bit_d;
  logic [DIV_W-1:0] baud_q, baud_d;
  logic [DIV_W-1:0] lat_q, lat_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic [7:0]       mem_q [FIFO_DEPTH];

  logic        full, empty;
  logic        is_tx, is_st, is_baud;
  logic        acc, push, pop, last;
  logic [31:0] status, rdata;
  logic        unused_bits;

  assign unused_bits = ^{req_addr[1:0], req_wdata[31:DIV_W]};

  assign full    = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign empty   = (cnt_q == '0);
  assign is_tx   = (req_addr[3:2] == 2'd0);
  assign is_st   = (req_addr[3:2] == 2'd1);
  assign is_baud = (req_addr[3:2] == 2'd2);

  // Stall only a TXDATA write into a full FIFO, judged on the
  // registered count so a same-cycle pop never unstalls.
  assign req_ready = !(req_valid && req_we && is_tx && full);
  assign acc       = req_valid && req_ready;
  assign push      = acc && req_we && is_tx;

  always_comb begin
    status      = '0;
    status[0]   = full;
    status[1]   = empty;
    status[2]   = busy_q;
    status[7:4] = 4'(cnt_q);
  end

  always_comb begin
    rdata = '0;
    if (!req_we) begin
      unique case (1'b1)
        is_st:   rdata = status;
        is_baud: rdata = 32'(div_q);
        default: rdata = '0;
      endcase
    end
  end

  always_comb begin
    rsp_valid_d = acc;
    rsp_rdata_d = acc ? rdata : '0;
    div_d       = div_q;
    if (acc && req_we && is_baud) begin
      div_d = req_wdata[DIV_W-1:0];
    end
  end

  always_comb begin
    wr_d  = push ? wr_q + PTR_W'(1) : wr_q;
    rd_d  = pop ? rd_q + PTR_W'(1) : rd_q;
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  assign last = (baud_q == lat_q - DIV_W'(1));

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    baud_d  = baud_q;
    lat_d   = lat_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_q];
          lat_d   = (div_q == '0) ? DIV_W'(1) : div_q;
          baud_d  = '0;
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (last) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + DIV_W'(1);
        end
      end
      DATA: begin
        if (last) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + DIV_W'(1);
        end
      end
      STOP: begin
        if (last) begin
          baud_d  = '0;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line and busy are registered from the current state.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_q != IDLE);
    unique case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[bit_q];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_q       <= '0;
      baud_q      <= '0;
      lat_q       <= DIV_W'(1);
      div_q       <= DIV_W'(CLKS_PER_BIT);
      cnt_q       <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_q       <= bit_d;
      baud_q      <= baud_d;
      lat_q       <= lat_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q] <= req_wdata[7:0];
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign uart_tx   = tx_q;
  assign tx_busy   = busy_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: directed bus steps plus random bytes,
// line waveform checked against frames built from queued bytes.
module tb_mmio_uart_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [3:0]  req_addr = 4'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        uart_tx;
  logic        tx_busy;

  mmio_uart_tx dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .uart_tx   (uart_tx),
    .tx_busy   (tx_busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscomp = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int busy_cnt = 0;

  logic [7:0] exp_b[$];
  int         exp_d[$];
  int         starts[$];
  bit         in_frame = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscomp++;
      $error("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Line monitor: each frame is start 0, 8 data bits LSB first,
  // stop 1, each held for the divider latched for that byte.
  initial begin
    bit         prev;
    int         idx, fdiv, ferr;
    logic [9:0] fbits;
    logic [7:0] b;
    prev = 1'b1;
    idx = 0; fdiv = 1; ferr = 0; fbits = '1; b = '0;
    forever begin
      @(negedge clk);
      if (tx_busy) busy_cnt++;
      if (!reset) begin
        in_frame = 1'b0;
        prev = 1'b1;
      end else begin
        if (!in_frame && prev && !uart_tx) begin
          chk("frame_expected", {31'b0, exp_b.size() != 0}, 1);
          if (exp_b.size() != 0) begin
            b = exp_b.pop_front();
            fdiv = exp_d.pop_front();
          end else begin
            b = 8'hxx;
            fdiv = 1;
          end
          fbits = {1'b1, b, 1'b0};
          in_frame = 1'b1;
          idx = 0;
          ferr = 0;
          starts.push_back(cyc);
        end
        if (in_frame) begin
          if (uart_tx !== fbits[idx / fdiv] || tx_busy !== 1'b1)
            ferr++;
          idx++;
          if (idx == 10 * fdiv) begin
            in_frame = 1'b0;
            chk($sformatf("frame_%h_div%0d", b, fdiv), ferr, 0);
          end
        end
        prev = uart_tx;
      end
    end
  end

  task automatic xfer(input bit we, input logic [3:0] a,
                      input logic [31:0] d, output logic [31:0] rd);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_we = we;
    req_addr = a;
    req_wdata = d;
    #1;
    while (!req_ready && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("ready", {31'b0, req_ready}, 1);
    @(posedge clk);
    @(negedge clk);
    acc_cyc = cyc;
    chk("rsp_valid", {31'b0, rsp_valid}, 1);
    rd = rsp_rdata;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] r;
    xfer(1'b1, a, d, r);
    chk("wr_rdata", r, 0);
  endtask

  task automatic rd_chk(input logic [3:0] a, input logic [31:0] e,
                        input string tag);
    logic [31:0] r;
    xfer(1'b0, a, 32'h0, r);
    chk(tag, r, e);
  endtask

  task automatic send(input logic [7:0] b, input int d);
    exp_b.push_back(b);
    exp_d.push_back(d);
    wr(4'h0, {24'h0, b});
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_we = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (!(exp_b.size() == 0 && !in_frame && !tx_busy) && n < limit) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("drain", {31'b0, exp_b.size() == 0 && !in_frame && !tx_busy}, 1);
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    while (!in_frame && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("frame_start", {31'b0, in_frame}, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, b0, s0, f0, low, n, d;
    logic [7:0] bt;

    // Reset held with a pending read request
    reset = 1'b0;
    req_valid = 1'b1;
    req_we = 1'b0;
    req_addr = 4'h4;
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'b0, uart_tx}, 1);
    chk("rst_rsp", {31'b0, rsp_valid}, 0);
    chk("rst_busy", {31'b0, tx_busy}, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_ready", {31'b0, req_ready}, 1);
    reset = 1'b1;
    idle();
    @(negedge clk);
    rd_chk(4'h4, 32'h2, "status_rst");
    rd_chk(4'h8, 32'd434, "baud_rst");
    idle();

    // Single byte, latency and busy length
    wr(4'h8, 4);
    exp_b.push_back(8'hA5);
    exp_d.push_back(4);
    wr(4'h0, 32'hA5);
    a = acc_cyc;
    idle();
    b0 = busy_cnt;
    wait_idle(500);
    chk("latency", starts[$], a + 2);
    chk("busy_len", busy_cnt - b0, 40);

    // FIFO full stall at div 8
    wr(4'h8, 8);
    s0 = starts.size();
    for (int k = 0; k < 6; k++) begin
      exp_b.push_back(8'h41 + 8'(k));
      exp_d.push_back(8);
    end
    wr(4'h0, 32'h41);
    a = acc_cyc;
    for (int k = 1; k < 5; k++) begin
      wr(4'h0, 32'h41 + k);
      chk($sformatf("b2b_acc%0d", k), acc_cyc, a + k);
    end
    wr(4'h0, 32'h46);
    chk("stall_release", acc_cyc, a + 83);
    rd_chk(4'h4, 32'h45, "status_full");
    idle();
    wait_idle(1500);
    chk("first_start", starts[s0], a + 2);
    for (int k = 1; k < 6; k++)
      chk($sformatf("gap%0d", k), starts[s0 + k] - starts[s0 + k - 1], 81);
    rd_chk(4'h4, 32'h2, "status_drained");
    idle();

    // Divider change during a frame
    wr(4'h8, 4);
    exp_b.push_back(8'h55);
    exp_d.push_back(4);
    exp_b.push_back(8'h66);
    exp_d.push_back(6);
    wr(4'h0, 32'h55);
    wr(4'h0, 32'h66);
    idle();
    wait_frame();
    wr(4'h8, 6);
    rd_chk(4'h8, 6, "baud_new");
    idle();
    wait_idle(500);

    // Unmapped offset and back-to-back responses
    wr(4'hC, 32'hDEADBEEF);
    rd_chk(4'hC, 0, "unmapped_rd");
    rd_chk(4'h9, 6, "baud_alias");
    rd_chk(4'h4, 32'h2, "status_after_unmapped");
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) rd_chk(4'h8, 6, "alt_rd");
      else wr(4'hC, i);
    end
    rd_chk(4'h0, 0, "txdata_rd");
    idle();
    @(negedge clk);
    chk("rsp_drop", {31'b0, rsp_valid}, 0);
    rd_chk(4'h4, 32'h2, "status_no_push");
    idle();

    // Random bytes at random dividers, 0 meaning 1
    for (int r = 0; r < 6; r++) begin
      d = $urandom_range(0, 5);
      wr(4'h8, d);
      rd_chk(4'h8, d, "baud_rand");
      n = $urandom_range(1, 6);
      for (int j = 0; j < n; j++) begin
        bt = 8'($urandom);
        send(bt, (d == 0) ? 1 : d);
      end
      idle();
      wait_idle(2000);
      rd_chk(4'h4, 32'h2, "status_rand");
      idle();
    end

    // Reset during data bit 3 of 0xF0
    wr(4'h8, 4);
    send(8'hF0, 4);
    send(8'h0F, 4);
    send(8'h33, 4);
    idle();
    wait_frame();
    s0 = starts[$];
    n = 0;
    while (cyc < s0 + 17 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bit3_low", {31'b0, uart_tx}, 0);
    #3;
    reset = 1'b0;
    #1;
    chk("abort_tx", {31'b0, uart_tx}, 1);
    chk("abort_busy", {31'b0, tx_busy}, 0);
    exp_b.delete();
    exp_d.delete();
    f0 = starts.size();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    rd_chk(4'h4, 32'h2, "status_post_rst");
    rd_chk(4'h8, 32'd434, "baud_post_rst");
    idle();
    low = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) low++;
    end
    chk("quiet_line", low, 0);
    chk("no_frame", starts.size(), f0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscomp);
    $finish;
  end

endmodule
